// File: rtl/exec_unit_mc_if.sv
// exec_unit_mc_if: decode-side request and write-back-side result bundle for exec_unit_mc.
interface exec_unit_mc_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W = 16
);
   logic start;
   logic [3:0] op;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] pc;
   logic [IMM_W-1:0] imm;
   logic busy;
   logic done;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] addr_o;
   logic zero;
   logic illegal;
   modport master (output start, op, a, b, pc, imm, input busy, done, result, addr_o, zero, illegal);
   modport slave (input start, op, a, b, pc, imm, output busy, done, result, addr_o, zero, illegal);
endinterface

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multicycle execute unit (single-cycle ALU, iterative shifts/multiply, branch target).
// Define EXEC_MUL_EN to build the shift-add multiplier for op 8; otherwise op 8 is illegal.
module exec_unit_mc #(
   parameter int DATA_W = 32,
   parameter int IMM_W = 16,
   parameter int SH_W = 5
) (
   input logic clk,
   input logic rst,
   exec_unit_mc_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, LATCH = 2'd1, ITER = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic [3:0] op_q;
   logic [DATA_W-1:0] a_q, b_q, tgt_q, w, alu, step, iter_val, fin_val;
   logic [SH_W:0] cnt;
   logic [SH_W-1:0] sh;
   logic is_shift, is_mul, illegal_op, fin;
   assign sh = b_q[SH_W-1:0];
   assign is_shift = op_q inside {4'd5, 4'd6, 4'd7};
   assign illegal_op = op_q > 4'd9 || (op_q == 4'd8 && !is_mul);
   // BEQ shares the subtractor, so zero = (a == b) falls out of result == 0
   assign alu = op_q == 4'd0 ? a_q + b_q :
                (op_q == 4'd1 || op_q == 4'd9) ? a_q - b_q :
                op_q == 4'd2 ? a_q & b_q :
                op_q == 4'd3 ? a_q | b_q :
                op_q == 4'd4 ? a_q ^ b_q : '0;
   assign step = op_q == 4'd6 ? w >> 1 :
                 op_q == 4'd7 ? {w[DATA_W-1], w[DATA_W-1:1]} : w << 1;
   assign fin_val = state == ITER ? iter_val : is_shift ? a_q : alu;
   assign fin = state == ITER ? cnt == (SH_W+1)'(1) :
                state == LATCH && !is_mul && !(is_shift && sh != '0);
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
`ifdef EXEC_MUL_EN
   logic [DATA_W-1:0] acc, m;
   assign is_mul = op_q == 4'd8;
   assign iter_val = is_mul ? acc + (m[0] ? w : '0) : step;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         m <= '0;
      end else if (state == LATCH) begin
         acc <= '0;
         m <= b_q;
      end else if (state == ITER) begin
         acc <= iter_val;
         m <= m >> 1;
      end
   end
`else
   assign is_mul = 1'b0;
   assign iter_val = step;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         tgt_q <= '0;
         w <= '0;
         cnt <= '0;
         bus.result <= '0;
         bus.addr_o <= '0;
         bus.zero <= 1'b0;
         bus.illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op_q <= bus.op;
               a_q <= bus.a;
               b_q <= bus.b;
               tgt_q <= bus.pc + {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
               state <= LATCH;
            end
            LATCH: begin
               w <= a_q;
               cnt <= is_mul ? (SH_W+1)'(DATA_W) : {1'b0, sh};
               state <= ITER;
            end
            ITER: begin
               w <= step;
               cnt <= cnt - (SH_W+1)'(1);
            end
            DONE: state <= IDLE;
         endcase
         if (fin) begin
            bus.result <= fin_val;
            bus.zero <= fin_val == '0;
            bus.illegal <= illegal_op;
            bus.addr_o <= tgt_q;
            state <= DONE;
         end
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: table-driven vectors with a done-side scoreboard, plus busy/done/reset corner sequences.
module tb_exec_unit_mc;
   typedef struct {
      logic [3:0] op;
      logic [31:0] a, b, pc;
      logic [15:0] imm;
      logic [31:0] res, addr;
      logic z, ill;
      int lat;
   } vec_t;

   logic clk = 0;
   logic rst = 1;
   int cyc = 0;
   int acc_cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   vec_t q[$];
   vec_t vecs[18];
   vec_t hv;

   exec_unit_mc_if #(.DATA_W(32), .IMM_W(16)) bus ();
   exec_unit_mc #(.DATA_W(32), .IMM_W(16), .SH_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // scoreboard: every done must match the oldest outstanding request
   always @(negedge clk) begin
      if (rst && bus.done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = q.pop_front();
            check("result", bus.result, e.res);
            check("zero", {31'd0, bus.zero}, {31'd0, e.z});
            check("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
            check("addr_o", bus.addr_o, e.addr);
            check("latency", cyc - acc_cyc, e.lat);
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
   endtask

   task automatic run(input vec_t v, input int poke, input bit poke_done);
      bit seen;
      wait_idle();
      @(negedge clk);
      bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.pc = v.pc; bus.imm = v.imm;
      bus.start = 1;
      q.push_back(v);
      @(posedge clk);
      #1 acc_cyc = cyc;
      bus.start = 0;
      bus.a = $urandom; bus.b = $urandom; bus.pc = $urandom; bus.imm = 16'($urandom);
      check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus.start = (i == poke);
         bus.op = 4'd0;
         if (bus.done) begin
            seen = 1;
            bus.start = poke_done;
            break;
         end
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         q.delete();
      end
      @(negedge clk);
      bus.start = 0;
      check("busy_after_done", {31'd0, bus.busy}, 32'd0);
      check("done_pulse_width", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.pc = 0; bus.imm = 0;
      vecs[0]  = '{4'd0, 32'd3, 32'd4, 32'h100, 16'h0010, 32'd7, 32'h110, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'd1, 32'd3, 32'd3, 32'h100, 16'h0010, 32'd0, 32'h110, 1'b1, 1'b0, 1};
      vecs[2]  = '{4'd2, 32'hf0f0, 32'hff00, 32'h100, 16'h0010, 32'hf000, 32'h110, 1'b0, 1'b0, 1};
      vecs[3]  = '{4'd3, 32'h0f, 32'hf0, 32'h100, 16'h0010, 32'hff, 32'h110, 1'b0, 1'b0, 1};
      vecs[4]  = '{4'd4, 32'hff, 32'h0f, 32'h100, 16'h0010, 32'hf0, 32'h110, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'd0, 32'hffffffff, 32'd1, 32'h100, 16'h8000, 32'd0, 32'hffff8100, 1'b1, 1'b0, 1};
      vecs[6]  = '{4'd5, 32'd1, 32'd31, 32'h100, 16'h0010, 32'h80000000, 32'h110, 1'b0, 1'b0, 32};
      vecs[7]  = '{4'd6, 32'h80000000, 32'd4, 32'h100, 16'h0010, 32'h08000000, 32'h110, 1'b0, 1'b0, 5};
      vecs[8]  = '{4'd7, 32'h80000000, 32'd4, 32'h100, 16'h0010, 32'hf8000000, 32'h110, 1'b0, 1'b0, 5};
      vecs[9]  = '{4'd7, 32'h12345678, 32'd0, 32'h100, 16'h0010, 32'h12345678, 32'h110, 1'b0, 1'b0, 1};
      vecs[10] = '{4'd7, 32'hf0000000, 32'h25, 32'h100, 16'h0010, 32'hff800000, 32'h110, 1'b0, 1'b0, 6};
      vecs[11] = '{4'd9, 32'd5, 32'd5, 32'h2, 16'h0004, 32'd0, 32'h6, 1'b1, 1'b0, 1};
      vecs[12] = '{4'd9, 32'd7, 32'd5, 32'h10, 16'hfffe, 32'd2, 32'he, 1'b0, 1'b0, 1};
`ifdef EXEC_MUL_EN
      vecs[13] = '{4'd8, 32'd6, 32'd7, 32'h100, 16'h0010, 32'd42, 32'h110, 1'b0, 1'b0, 33};
`else
      vecs[13] = '{4'd8, 32'd6, 32'd7, 32'h100, 16'h0010, 32'd0, 32'h110, 1'b1, 1'b1, 1};
`endif
      vecs[14] = '{4'd12, 32'd9, 32'd3, 32'h100, 16'h0010, 32'd0, 32'h110, 1'b1, 1'b1, 1};
      vecs[15] = '{4'd6, 32'hffffffff, 32'd31, 32'h100, 16'h0010, 32'd1, 32'h110, 1'b0, 1'b0, 32};
      vecs[16] = '{4'd1, 32'd0, 32'd1, 32'h100, 16'h0010, 32'hffffffff, 32'h110, 1'b0, 1'b0, 1};
      vecs[17] = '{4'd5, 32'h80000001, 32'd1, 32'h100, 16'h0010, 32'd2, 32'h110, 1'b0, 1'b0, 2};
      #3 rst = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_addr_o", bus.addr_o, 32'd0);
      check("rst_zero", {31'd0, bus.zero}, 32'd0);
      check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      rst = 1;
      for (int i = 0; i < 18; i++) run(vecs[i], -1, 1'b0);
      // start pulsed mid-operation and during the done cycle must both be dropped
      hv = '{4'd6, 32'hffffffff, 32'd20, 32'h40, 16'h0001, 32'h00000fff, 32'h41, 1'b0, 1'b0, 21};
      run(hv, 5, 1'b1);
      run(vecs[13], 10, 1'b1);
      repeat (4) @(negedge clk);
      check("idle_after_ignored_start", {31'd0, bus.busy}, 32'd0);
      // async reset in the middle of an iterative op
      @(negedge clk);
      bus.op = 4'd6; bus.a = 32'hffffffff; bus.b = 32'd20; bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      repeat (10) @(negedge clk);
      #2 rst = 0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_result", bus.result, 32'd0);
      check("abort_addr_o", bus.addr_o, 32'd0);
      @(negedge clk);
      rst = 1;
      repeat (30) @(negedge clk);
      hv = '{4'd5, 32'h3, 32'd3, 32'h0, 16'h0008, 32'h18, 32'h8, 1'b0, 1'b0, 4};
      run(hv, -1, 1'b0);
      repeat (10) @(negedge clk);
      check("scoreboard_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
